packet_tx_framer: RTL

//  Transmit-side counterpart of the packet detector: builds one complex baseband frame per start pulse.

---
 rtl/packet_tx_framer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/packet_tx_framer.sv
// packet_tx_framer: builds one frame per start pulse -- PRE_REP repeated
// preamble periods, len_i payload samples from the upstream stream, then
// GUARD_LEN zero samples -- onto a valid/ready I/Q output stream.
module packet_tx_framer #(
  parameter int          PRE_LEN   = 16,
  parameter int          PRE_REP   = 10,
  parameter int          GUARD_LEN = 8,
  parameter logic [15:0] AMP       = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [11:0] len_i,
  input  logic [15:0] in_i_i,
  input  logic [15:0] in_q_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [15:0] out_i_o,
  output logic [15:0] out_q_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int          SW        = $clog2(PRE_LEN);
  localparam logic [15:0] NEG_AMP   = 16'd0 - AMP;
  localparam logic [SW-1:0] SAMP_LAST = SW'(PRE_LEN - 1);
  localparam logic [7:0]  REP_LAST  = 8'(PRE_REP - 1);
  localparam logic [7:0]  GRD_END   = 8'(GUARD_LEN);

  typedef enum logic [2:0] {IDLE, PRE, PAY, GRD, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [7:0]    rep_cnt_q, rep_cnt_d;
  logic [11:0]   pay_cnt_q, pay_cnt_d;
  logic [7:0]    grd_cnt_q, grd_cnt_d;
  logic [11:0]   len_q, len_d;
  logic [15:0]   out_i_q, out_i_d;
  logic [15:0]   out_q_q, out_q_d;
  logic          out_valid_q, out_valid_d;

  logic          advance;
  logic          pay_accept;
  logic [15:0]   rom_i;
  logic [15:0]   rom_q;

  // The output slice may take a new sample when empty or being drained.
  assign advance    = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == PAY) && advance && (pay_cnt_q < len_q);
  assign pay_accept = in_valid_i && in_ready_o;

  assign out_i_o     = out_i_q;
  assign out_q_o     = out_q_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q == PRE) || (state_q == PAY) || (state_q == GRD);
  assign done_o      = (state_q == DONE);

  // Preamble ROM: QPSK-like points of constant magnitude selected by index bits.
  always_comb begin
    rom_i = ((((samp_cnt_q >> 1) ^ (samp_cnt_q >> 3)) & SW'(1)) != '0) ? NEG_AMP : AMP;
    rom_q = (((samp_cnt_q >> 2) & SW'(1)) != '0) ? NEG_AMP : AMP;
  end

  // Next-state, counter and output-slice logic; samp_cnt holds the index of the next preamble sample to emit.
  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    grd_cnt_d   = grd_cnt_q;
    len_d       = len_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (start_i) begin
          len_d       = len_i;
          samp_cnt_d  = SW'(1);
          rep_cnt_d   = 8'd0;
          pay_cnt_d   = 12'd0;
          grd_cnt_d   = 8'd0;
          out_i_d     = AMP;
          out_q_d     = AMP;
          out_valid_d = 1'b1;
          state_d     = PRE;
        end
      end

      PRE: begin
        if (advance) begin
          out_i_d     = rom_i;
          out_q_d     = rom_q;
          out_valid_d = 1'b1;
          samp_cnt_d  = samp_cnt_q + SW'(1);
          if (samp_cnt_q == SAMP_LAST) begin
            rep_cnt_d = rep_cnt_q + 8'd1;
            if (rep_cnt_q == REP_LAST) begin
              rep_cnt_d = 8'd0;
              state_d   = (len_q == 12'd0) ? GRD : PAY;
            end
          end
        end
      end

      PAY: begin
        if (advance) begin
          if (pay_accept) begin
            out_i_d     = in_i_i;
            out_q_d     = in_q_i;
            out_valid_d = 1'b1;
            pay_cnt_d   = pay_cnt_q + 12'd1;
            if (pay_cnt_q == len_q - 12'd1) begin
              state_d = GRD;
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end

      GRD: begin
        if (advance) begin
          if (grd_cnt_q != GRD_END) begin
            out_i_d     = 16'd0;
            out_q_d     = 16'd0;
            out_valid_d = 1'b1;
            grd_cnt_d   = grd_cnt_q + 8'd1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      samp_cnt_q  <= '0;
      rep_cnt_q   <= 8'd0;
      pay_cnt_q   <= 12'd0;
      grd_cnt_q   <= 8'd0;
      len_q       <= 12'd0;
      out_i_q     <= 16'd0;
      out_q_q     <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      grd_cnt_q   <= grd_cnt_d;
      len_q       <= len_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
